// File: rtl/mix_pkg.sv
// Shared types and constants for the mix datapath consumers.
// The Result width here must track the mix core's output register.
package mix_pkg;

    typedef enum logic {ACCUM, HOLD} mix_acc_state_t;

    localparam int MIX_DATA_W = 8;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mix_minmax_trk.sv
// Running minimum/maximum tracker for one block of unsigned samples.
// upd_min/upd_max show the values including the sample offered this cycle.
module mix_minmax_trk
    import mix_pkg::*;
#(
    parameter int DATA_W = MIX_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              update,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] upd_min,
    output logic [DATA_W-1:0] upd_max
);

    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;

    // Strict compares so ties keep the stored value.
    assign upd_min = (data < run_min) ? data : run_min;
    assign upd_max = (data > run_max) ? data : run_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_min <= '1;
            run_max <= '0;
        end else if (init) begin
            run_min <= '1;
            run_max <= '0;
        end else if (update) begin
            run_min <= upd_min;
            run_max <= upd_max;
        end
    end

endmodule

// File: rtl/mix_result_accum.sv
// Reduces each block of COUNT Result samples to sum/min/max and offers one
// summary per block downstream; input is stalled while a summary is pending.
module mix_result_accum
    import mix_pkg::*;
#(
    parameter int  DATA_W = MIX_DATA_W,
    parameter int  COUNT  = 16,
    localparam int ACC_W  = DATA_W + clog2(COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max
);

    localparam int CNT_W = clog2(COUNT);

    mix_acc_state_t    state;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [DATA_W-1:0] upd_min;
    logic [DATA_W-1:0] upd_max;
    logic              accept;
    logic              last;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready is a flop set only in ACCUM, so it never depends
    // combinationally on in_valid/out_ready; clear overrides any transfer.
    assign accept  = in_valid && in_ready && !clear;
    assign last    = accept && (cnt == CNT_W'(COUNT - 1));
    assign acc_nxt = acc + ACC_W'(in_data);

    mix_minmax_trk #(.DATA_W(DATA_W)) u_minmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (clear || last),
        .update  (accept),
        .data    (in_data),
        .upd_min (upd_min),
        .upd_max (upd_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (clear || last) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_min   <= '0;
            out_max   <= '0;
        end else if (clear) begin
            // Summary data registers deliberately keep their last contents.
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (last) begin
                        out_sum   <= acc_nxt;
                        out_min   <= upd_min;
                        out_max   <= upd_max;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state    <= ACCUM;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_result_accum.sv
// Directed and randomized-gap checks of mix_result_accum at COUNT=16 and COUNT=5.
module tb_mix_result_accum;
    import mix_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // COUNT=16 instance
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data   = '0;
    logic        clear     = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_sum;
    logic [7:0]  out_min;
    logic [7:0]  out_max;

    // COUNT=5 instance
    logic        in_valid5  = 1'b0;
    logic        in_ready5;
    logic [7:0]  in_data5   = '0;
    logic        clear5     = 1'b0;
    logic        out_valid5;
    logic        out_ready5 = 1'b1;
    logic [10:0] out_sum5;
    logic [7:0]  out_min5;
    logic [7:0]  out_max5;

    int n_vec  = 0;
    int n_miss = 0;
    bit rand_rdy = 1'b0;

    logic [27:0] exp16_q[$];
    logic [26:0] exp5_q[$];

    mix_result_accum #(.DATA_W(8), .COUNT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_min(out_min), .out_max(out_max)
    );

    mix_result_accum #(.DATA_W(8), .COUNT(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_data(in_data5), .clear(clear5), .out_valid(out_valid5), .out_ready(out_ready5),
        .out_sum(out_sum5), .out_min(out_min5), .out_max(out_max5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare whenever a summary handshake is about to complete.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp16_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL blk16_extra: got summary %0h/%0h/%0h, expected none", out_sum, out_min, out_max);
            end else begin
                check("blk16", {4'h0, out_sum, out_min, out_max}, {4'h0, exp16_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid5 && out_ready5) begin
            if (exp5_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL blk5_extra: got summary %0h/%0h/%0h, expected none", out_sum5, out_min5, out_max5);
            end else begin
                check("blk5", {5'h0, out_sum5, out_min5, out_max5}, {5'h0, exp5_q.pop_front()});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready5 = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic send16(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready && !clear) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL send16_timeout: in_ready 0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send5(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        in_valid5 = 1'b1;
        in_data5  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready5) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL send5_timeout: in_ready 0, expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  smp[5];
        logic [10:0] s5;
        logic [7:0]  mn5;
        logic [7:0]  mx5;

        // Reset values
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", {out_sum, out_min, out_max}, 0);
        #21 rst_n = 1'b1;
        #1 check("ready_before_edge", in_ready, 0);
        tick();
        check("ready_after_release", in_ready, 1);

        // 1: reset mid-block
        for (int i = 0; i < 5; i++) send16(8'd100);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        exp16_q.push_back({12'd136, 8'd1, 8'd16});
        for (int i = 1; i <= 16; i++) send16(8'(i));
        tick();

        // 2: basic block 0..15
        exp16_q.push_back({12'd120, 8'd0, 8'd15});
        for (int i = 0; i < 16; i++) send16(8'(i));
        check("basic_valid_ready", {out_valid, in_ready}, 2'b10);
        tick();
        check("basic_after_hs", {out_valid, in_ready}, 2'b01);

        // 3: full scale then zeros, back to back
        exp16_q.push_back({12'hFF0, 8'hFF, 8'hFF});
        exp16_q.push_back({12'h000, 8'h00, 8'h00});
        for (int i = 0; i < 16; i++) send16(8'hFF);
        for (int i = 0; i < 16; i++) send16(8'h00);
        tick();

        // 4: backpressure
        out_ready = 1'b0;
        exp16_q.push_back({12'd280, 8'd10, 8'd25});
        exp16_q.push_back({12'd114, 8'd1, 8'd99});
        for (int i = 0; i < 16; i++) send16(8'(10 + i));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd99;
            check("bp_hold", {out_valid, in_ready, out_sum, out_min, out_max},
                  {1'b1, 1'b0, 12'd280, 8'd10, 8'd25});
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release", {out_valid, in_ready}, 2'b01);
        send16(8'd99);
        for (int i = 0; i < 15; i++) send16(8'd1);
        tick();

        // 5a: clear drops partial block and the sample offered with it
        for (int i = 0; i < 7; i++) send16(8'd50);
        in_valid = 1'b1;
        in_data  = 8'd200;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_in_ready", in_ready, 1);
        exp16_q.push_back({12'd32, 8'd2, 8'd2});
        for (int i = 0; i < 16; i++) send16(8'd2);
        tick();

        // 5b: clear while a summary is held
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send16(8'd5);
        check("hold_valid", out_valid, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("hold_clr", {out_valid, in_ready, out_sum}, {1'b0, 1'b1, 12'd80});
        out_ready = 1'b1;
        repeat (3) tick();
        check("hold_clr_quiet", out_valid, 0);

        // 6: COUNT=5, random gaps and random out_ready
        rand_rdy = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            s5  = '0;
            mn5 = 8'hFF;
            mx5 = 8'h00;
            for (int k = 0; k < 5; k++) begin
                smp[k] = (b % 50 == 0) ? ((k % 2) ? 8'hFF : 8'h00) : 8'($urandom_range(0, 255));
                s5 = s5 + 11'(smp[k]);
                if (smp[k] < mn5) mn5 = smp[k];
                if (smp[k] > mx5) mx5 = smp[k];
            end
            exp5_q.push_back({s5, mn5, mx5});
            for (int k = 0; k < 5; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                send5(smp[k]);
            end
        end
        for (int t = 0; t < 200 && exp5_q.size() != 0; t++) tick();
        rand_rdy = 1'b0;
        repeat (3) tick();

        check("q16_drained", exp16_q.size(), 0);
        check("q5_drained", exp5_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
